// File: rtl/ulpi_pkg.sv
// ulpi_pkg: command codes, register addresses, abort byte and FSM encoding
// shared by the ULPI link and the PHY responder.
package ulpi_pkg;
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;
  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;
  localparam logic [5:0] ADDR_VID_LO = 6'h00;
  localparam logic [5:0] ADDR_VID_HI = 6'h01;
  localparam logic [5:0] ADDR_PID_LO = 6'h02;
  localparam logic [5:0] ADDR_PID_HI = 6'h03;
  localparam logic [7:0] ABORT_BYTE = 8'hFF;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD_ACK, S_REGW_DATA, S_REGW_STP, S_REGR_TURN, S_REGR_DATA,
    S_TX_DATA, S_RX_TURN, S_RX_DATA, S_RXCMD_TURN, S_RXCMD_DATA
  } state_t;
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction
endpackage

// File: rtl/ulpi_reg_file.sv
// ulpi_reg_file: 64x8 PHY register map; the four ID bytes are read-only constants.
module ulpi_reg_file
  import ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [5:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] mem_q [64];
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    else if (we_i && waddr_i > ADDR_PID_HI) mem_q[waddr_i] <= wdata_i;
  always_comb
    rdata_o = raddr_i == ADDR_VID_LO ? VENDOR_ID[7:0]   :
              raddr_i == ADDR_VID_HI ? VENDOR_ID[15:8]  :
              raddr_i == ADDR_PID_LO ? PRODUCT_ID[7:0]  :
              raddr_i == ADDR_PID_HI ? PRODUCT_ID[15:8] : mem_q[raddr_i];
endmodule

// File: rtl/ulpi_phy_responder.sv
// ulpi_phy_responder: ULPI PHY model answering link TX CMDs and injecting
// RX packets / line-state RX CMDs; every output is a register.
module ulpi_phy_responder
  import ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       ulpi_clk_i,
  input  logic       ulpi_rst_n_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_dir_o,
  output logic       ulpi_nxt_o,
  input  logic       ulpi_stp_i,
  input  logic [1:0] linestate_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_last_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       tx_eop_o,
  output logic       tx_abort_o
);
  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d, hold_q, hold_d, dout_q, dout_d, txd_q, txd_d, rdata, ls_cmd;
  logic [1:0] ls_q, ls_d;
  logic dir_q, dir_d, nxt_q, nxt_d, rdy_q, rdy_d, txv_q, txv_d;
  logic eop_q, eop_d, abt_q, abt_d, last_q, last_d, consume, rx_acc;
  assign consume = nxt_q && !dir_q && !ulpi_stp_i;
  assign rx_acc  = rx_valid_i && rdy_q;
  assign ls_cmd  = {6'b0, linestate_i};
  ulpi_reg_file #(.VENDOR_ID(VENDOR_ID), .PRODUCT_ID(PRODUCT_ID)) u_regs (
    .clk_i(ulpi_clk_i), .rst_n_i(ulpi_rst_n_i),
    .we_i(state_q == S_REGW_DATA && consume), .waddr_i(cmd_q[5:0]), .wdata_i(ulpi_data_i),
    .raddr_i(cmd_q[5:0]), .rdata_o(rdata)
  );
  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    hold_d = hold_q;
    ls_d = ls_q;
    txd_d = txd_q;
    dout_d = '0;
    dir_d = 1'b0;
    nxt_d = 1'b0;
    rdy_d = 1'b0;
    txv_d = 1'b0;
    eop_d = 1'b0;
    abt_d = 1'b0;
    last_d = 1'b0;
    case (state_q)
      S_IDLE:
        if (ulpi_data_i != '0) begin
          state_d = S_CMD_ACK;
          cmd_d = ulpi_data_i;
          nxt_d = 1'b1;
        end else if (rx_valid_i) begin
          state_d = S_RX_TURN;
          dir_d = 1'b1;
          rdy_d = 1'b1;
        end else if (linestate_i != ls_q) begin
          state_d = S_RXCMD_TURN;
          dir_d = 1'b1;
        end
      S_CMD_ACK: begin
        hold_d = pid_byte(cmd_q[3:0]);
        state_d = cmd_q[7:6] == CMD_TX   ? S_TX_DATA   :
                  cmd_q[7:6] == CMD_REGW ? S_REGW_DATA :
                  cmd_q[7:6] == CMD_REGR ? S_REGR_TURN : S_IDLE;
        nxt_d = cmd_q[7:6] == CMD_TX || cmd_q[7:6] == CMD_REGW;
        dir_d = cmd_q[7:6] == CMD_REGR && cmd_q[7:6] != CMD_IDLE;
      end
      S_REGW_DATA: state_d = S_REGW_STP;
      S_REGW_STP:  state_d = S_IDLE;
      S_REGR_TURN: begin
        state_d = S_REGR_DATA;
        dir_d = 1'b1;
        dout_d = rdata;
      end
      S_REGR_DATA: state_d = S_IDLE;
      // The held byte lags consumption by one, so STP can still tag or drop it.
      S_TX_DATA: begin
        txd_d = hold_q;
        if (ulpi_stp_i) begin
          state_d = S_IDLE;
          abt_d = ulpi_data_i == ABORT_BYTE;
          txv_d = ulpi_data_i != ABORT_BYTE;
          eop_d = ulpi_data_i != ABORT_BYTE;
        end else begin
          nxt_d = 1'b1;
          txv_d = 1'b1;
          hold_d = ulpi_data_i;
        end
      end
      S_RX_TURN, S_RX_DATA:
        if (state_q == S_RX_DATA && last_q) state_d = S_IDLE;
        else begin
          state_d = S_RX_DATA;
          dir_d = 1'b1;
          nxt_d = rx_acc;
          dout_d = rx_acc ? rx_data_i : ls_cmd;
          last_d = rx_acc && rx_last_i;
          rdy_d = !(rx_acc && rx_last_i);
        end
      S_RXCMD_TURN: begin
        state_d = S_RXCMD_DATA;
        dir_d = 1'b1;
        dout_d = ls_cmd;
        ls_d = linestate_i;
      end
      S_RXCMD_DATA: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ulpi_clk_i or negedge ulpi_rst_n_i)
    if (!ulpi_rst_n_i) begin
      state_q <= S_IDLE;
      cmd_q <= '0;
      hold_q <= '0;
      ls_q <= '0;
      txd_q <= '0;
      dout_q <= '0;
      dir_q <= 1'b0;
      nxt_q <= 1'b0;
      rdy_q <= 1'b0;
      txv_q <= 1'b0;
      eop_q <= 1'b0;
      abt_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      hold_q <= hold_d;
      ls_q <= ls_d;
      txd_q <= txd_d;
      dout_q <= dout_d;
      dir_q <= dir_d;
      nxt_q <= nxt_d;
      rdy_q <= rdy_d;
      txv_q <= txv_d;
      eop_q <= eop_d;
      abt_q <= abt_d;
      last_q <= last_d;
    end
  assign ulpi_data_o = dout_q;
  assign ulpi_dir_o  = dir_q;
  assign ulpi_nxt_o  = nxt_q;
  assign rx_ready_o  = rdy_q;
  assign tx_data_o   = txd_q;
  assign tx_valid_o  = txv_q;
  assign tx_eop_o    = eop_q;
  assign tx_abort_o  = abt_q;
endmodule

// File: tb/tb_ulpi_phy_responder.sv
// tb_ulpi_phy_responder: randomized link-side stimulus checked against a
// transaction-level model of the PHY register map, TX and RX streams.
module tb_ulpi_phy_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] data_i = '0, rx_data = '0, data_o, tx_data;
  logic stp = 1'b0, rx_valid = 1'b0, rx_last = 1'b0;
  logic [1:0] ls = '0, ls_rep;
  logic dir, nxt, rx_ready, tx_valid, tx_eop, tx_abort;
  int tests = 0, fails = 0, aborts = 0;
  logic [7:0] mdl [64];
  logic [8:0] dq[$];
  logic [8:0] tq[$];
  logic [7:0] pkt[$];
  int gaps[$];

  ulpi_phy_responder dut (
    .ulpi_clk_i(clk), .ulpi_rst_n_i(rst_n), .ulpi_data_i(data_i), .ulpi_data_o(data_o),
    .ulpi_dir_o(dir), .ulpi_nxt_o(nxt), .ulpi_stp_i(stp), .linestate_i(ls),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_last_i(rx_last), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_eop_o(tx_eop), .tx_abort_o(tx_abort)
  );

  always #8 clk = ~clk;

  // Bus-ownership cycles as {nxt,data_o}; TX bytes as {eop,data}.
  always @(negedge clk) begin
    if (dir) dq.push_back({nxt, data_o});
    if (tx_valid) tq.push_back({tx_eop, tx_data});
    if (tx_abort) aborts++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    ls_rep = 2'b00;
  endtask

  function automatic logic [7:0] exp_reg(input logic [5:0] a);
    return a == 6'd0 ? 8'h24 : a == 6'd1 ? 8'h04 : a == 6'd2 ? 8'h09 : a == 6'd3 ? 8'h00 : mdl[a];
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    logic [2:0] pat;
    data_i = {2'b10, a};
    tick; pat[2] = nxt;
    tick; pat[1] = nxt; data_i = d;
    tick; pat[0] = nxt; data_i = 8'h00; stp = 1'b1;
    tick; stp = 1'b0;
    if (a > 6'd3) mdl[a] = d;
    tests++;
    if (pat !== 3'b110) begin $display("FAIL wr_nxt_%02h: got %b want 110", a, pat); fails++; end
  endtask

  task automatic test_read(input logic [5:0] a);
    logic [2:0] dpat;
    logic [7:0] turn, d;
    data_i = {2'b11, a};
    tick;
    tick; data_i = 8'h00; dpat[2] = dir; turn = data_o;
    tick; dpat[1] = dir; d = data_o;
    tick; dpat[0] = dir;
    tests++;
    if ({dpat, turn} !== {3'b110, 8'h00}) begin
      $display("FAIL rd_dir_%02h: got dir=%b turn=%02h want dir=110 turn=00", a, dpat, turn); fails++;
    end
    tests++;
    if (d !== exp_reg(a)) begin $display("FAIL rd_%02h: got %02h want %02h", a, d, exp_reg(a)); fails++; end
  endtask

  task automatic run_tx(input logic [3:0] pid, input bit abort);
    logic [7:0] seq[$];
    logic [8:0] exp[$];
    logic [7:0] tmp;
    tq.delete(); aborts = 0;
    seq.push_back({~pid, pid});
    foreach (pkt[i]) seq.push_back(pkt[i]);
    if (abort) tmp = seq.pop_back();
    foreach (seq[i]) exp.push_back({!abort && i == seq.size() - 1, seq[i]});
    data_i = {4'b0100, pid};
    tick; tick;
    tests++;
    if (nxt !== 1'b1) begin $display("FAIL tx_nxt: got %b want 1", nxt); fails++; end
    foreach (pkt[i]) begin data_i = pkt[i]; tick; end
    stp = 1'b1;
    data_i = abort ? 8'hFF : 8'($urandom_range(0, 254));
    tick; stp = 1'b0; data_i = 8'h00;
    tick; tick;
    tests++;
    if (tq.size() != exp.size() || aborts != int'(abort)) begin
      $display("FAIL tx_count: got bytes=%0d aborts=%0d want bytes=%0d aborts=%0d", tq.size(), aborts, exp.size(), abort);
      fails++;
    end else foreach (exp[i]) begin
      tests++;
      if (tq[i] !== exp[i]) begin $display("FAIL tx_byte%0d: got eop/data %h want %h", i, tq[i], exp[i]); fails++; end
    end
  endtask

  task automatic run_rx;
    logic [8:0] exp[$];
    bit acc;
    dq.delete();
    foreach (pkt[i]) begin
      if (i > 0) repeat (gaps[i]) exp.push_back({1'b0, 6'b0, ls});
      exp.push_back({1'b1, pkt[i]});
    end
    foreach (pkt[i]) begin
      if (i > 0) repeat (gaps[i]) begin rx_valid = 1'b0; tick; end
      rx_valid = 1'b1; rx_data = pkt[i]; rx_last = i == pkt.size() - 1;
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin acc = rx_ready; tick; end
      if (!acc) begin tests++; fails++; $display("FAIL rx_accept%0d: got no RX_READY within 20 cycles want accept", i); end
    end
    rx_valid = 1'b0; rx_last = 1'b0;
    for (int w = 0; w < 10 && dir; w++) tick;
    tests++;
    if (dq.size() != exp.size() + 1 || dq[0][8] !== 1'b0) begin
      $display("FAIL rx_len: got %0d dir cycles want %0d", dq.size(), exp.size() + 1); fails++;
    end else foreach (exp[i]) begin
      tests++;
      if (dq[i+1] !== exp[i]) begin $display("FAIL rx_cycle%0d: got nxt/data %h want %h", i, dq[i+1], exp[i]); fails++; end
    end
  endtask

  task automatic run_linestate(input logic [1:0] v);
    dq.delete(); ls = v;
    repeat (5) tick;
    tests++;
    if (v != ls_rep) begin
      if (dq.size() != 2 || dq[0][8] !== 1'b0 || dq[1] !== {1'b0, 6'b0, v})
        begin $display("FAIL rxcmd_%b: got %0d dir cycles last=%h want 2 last=%h", v, dq.size(), dq.size() > 0 ? dq[dq.size()-1] : 9'h0, {1'b0, 6'b0, v}); fails++; end
    end else if (dq.size() != 0) begin
      $display("FAIL rxcmd_quiet_%b: got %0d dir cycles want 0", v, dq.size()); fails++;
    end
    ls_rep = v;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    tests++;
    if ({dir, nxt, rx_ready, tx_valid, tx_eop, tx_abort, data_o} !== 14'h0) begin
      $display("FAIL reset_outs: got dir=%b nxt=%b rdy=%b txv=%b eop=%b abt=%b dout=%02h want all 0", dir, nxt, rx_ready, tx_valid, tx_eop, tx_abort, data_o);
      fails++;
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_regs;
    do_write(6'h16, 8'h5A);
    test_read(6'h16);
    for (int k = 0; k < 8; k++) begin
      do_write(6'($urandom), 8'($urandom));
      test_read(6'($urandom));
    end
  endtask

  task automatic test_id;
    test_read(6'h00);
    test_read(6'h01);
    do_write(6'h02, 8'($urandom));
    test_read(6'h02);
    test_read(6'h03);
  endtask

  task automatic test_tx;
    pkt = '{8'h11, 8'h22};
    run_tx(4'h3, 1'b0);
    pkt = '{8'h33};
    run_tx(4'h1, 1'b1);
  endtask

  task automatic test_linestate;
    for (int k = 0; k < 3; k++) run_linestate(2'($urandom));
    run_linestate(2'b01);
  endtask

  task automatic test_rx;
    pkt = '{8'hA5, 8'h3C}; gaps = '{0, 1};
    run_rx;
    for (int k = 0; k < 3; k++) begin
      pkt.delete(); gaps.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        pkt.push_back(8'($urandom)); gaps.push_back(int'($urandom_range(0, 2)));
      end
      run_rx;
    end
  endtask

  task automatic test_collision;
    logic [3:0] rdy;
    logic [7:0] d, b;
    bit acc;
    d = 8'($urandom); b = 8'($urandom);
    dq.delete();
    rx_valid = 1'b1; rx_data = b; rx_last = 1'b1; data_i = 8'h8A;
    tick; rdy[3] = rx_ready;
    tests++;
    if ({nxt, dir} !== 2'b10) begin $display("FAIL coll_ack: got nxt=%b dir=%b want nxt=1 dir=0", nxt, dir); fails++; end
    tick; rdy[2] = rx_ready; data_i = d;
    tick; rdy[1] = rx_ready; data_i = 8'h00; stp = 1'b1;
    tick; rdy[0] = rx_ready; stp = 1'b0;
    mdl[6'h0A] = d;
    tests++;
    if (rdy !== 4'b0000) begin $display("FAIL coll_rdy: got %b want 0000", rdy); fails++; end
    acc = 1'b0;
    for (int w = 0; w < 20 && !acc; w++) begin acc = rx_ready; tick; end
    rx_valid = 1'b0; rx_last = 1'b0;
    for (int w = 0; w < 10 && dir; w++) tick;
    tests++;
    if (!acc || dq.size() != 2 || dq[1] !== {1'b1, b}) begin
      $display("FAIL coll_rx: got accepted=%b cycles=%0d want accepted=1 cycles=2 last=%h", acc, dq.size(), {1'b1, b}); fails++;
    end
    test_read(6'h0A);
  endtask

  task automatic test_random_mix;
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 3))
        0: do_write(6'($urandom), 8'($urandom));
        1: test_read(6'($urandom));
        2: begin
          pkt.delete();
          for (int i = 0; i < int'($urandom_range(0, 4)); i++) pkt.push_back(8'($urandom));
          run_tx(4'($urandom), 1'($urandom));
        end
        default: begin
          pkt.delete(); gaps.delete();
          for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
            pkt.push_back(8'($urandom)); gaps.push_back(int'($urandom_range(0, 2)));
          end
          run_rx;
        end
      endcase
    end
  endtask

  task automatic test_async_reset;
    rx_valid = 1'b1; rx_last = 1'b0; rx_data = 8'($urandom);
    tick; tick; tick;
    tests++;
    if (dir !== 1'b1) begin $display("FAIL arst_pre: got dir=%b want 1", dir); fails++; end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({dir, nxt, rx_ready, tx_eop, tx_abort} !== 5'b0) begin
      $display("FAIL arst_async: got dir=%b nxt=%b rdy=%b eop=%b abt=%b want all 0", dir, nxt, rx_ready, tx_eop, tx_abort); fails++;
    end
    rx_valid = 1'b0; ls = 2'b00;
    tick; tick;
    rst_n = 1'b1;
    model_reset;
    tick;
    test_read(6'h16);
    test_read(6'($urandom_range(4, 63)));
  endtask

  initial begin
    model_reset;
    test_reset;
    test_regs;
    test_id;
    test_tx;
    test_linestate;
    test_rx;
    test_collision;
    test_random_mix;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at %0t want finish before 1000000", $time);
    $fatal(1);
  end
endmodule

// File: doc/ulpi_phy_responder.md
# ulpi_phy_responder

PHY-side counterpart of our ULPI link interface: a synthesizable ULPI PHY model that answers link TX CMDs (register write, register read, transmit) and injects RX packets and RX CMDs toward the link. It sits in the loopback test harness, pin-to-pin with the link block. Data pins are split into in/out because the tri-state buffer lives at the top level.

## Interface
- VENDOR_ID, 16'h0424: read-only value at register addresses 0x00 (low byte) and 0x01 (high byte).
- PRODUCT_ID, 16'h0009: read-only value at addresses 0x02 (low byte) and 0x03 (high byte).
- ULPI_CLK  in  1  60 MHz clock; all logic on the rising edge.
- ULPI_RST_N  in  1  asynchronous, active-low reset.
- ULPI_DATA_IN  in  8  byte driven by the link; valid when ULPI_DIR=0.
- ULPI_DATA_OUT  out  8  byte driven toward the link; meaningful when ULPI_DIR=1.
- ULPI_DIR  out  1  1 = PHY owns the bus.
- ULPI_NXT  out  1  PHY throttle / data strobe.
- ULPI_STP  in  1  stop from the link.
- LINESTATE  in  2  current USB line state.
- RX_DATA  in  8  packet byte to deliver to the link.
- RX_VALID  in  1  RX_DATA valid.
- RX_LAST  in  1  marks the final byte of the packet.
- RX_READY  out  1  RX byte accepted at this edge when RX_VALID=1.
- TX_DATA  out  8  packet byte received from the link.
- TX_VALID  out  1  one-cycle strobe per TX_DATA byte.
- TX_EOP  out  1  set with the final TX_VALID of a packet.
- TX_ABORT  out  1  one-cycle pulse when the link aborts a transmit.

## Operation
- A link byte is consumed at a rising edge where ULPI_NXT=1, ULPI_DIR=0 and ULPI_STP=0.
- TX CMD decode on ULPI_DATA_IN[7:6]:
  - 00: idle.
  - 01: transmit; PID = [3:0].
  - 10: register write; address = [5:0].
  - 11: register read; address = [5:0].
- States: IDLE, CMD_ACK, REGW_DATA, REGW_STP, REGR_TURN, REGR_DATA, TX_DATA, RX_TURN, RX_DATA, RXCMD_TURN, RXCMD_DATA.
- Arbitration in IDLE, evaluated each edge:
  - Nonzero ULPI_DATA_IN → CMD_ACK.
  - Otherwise RX_VALID=1 → RX_TURN.
  - Otherwise LINESTATE differs from the last reported value → RXCMD_TURN.
  - A command and a pending RX in the same cycle: the command wins. RX waits; RX_READY stays 0.
- CMD_ACK: NXT=1 for one cycle, which consumes the command byte. Next state: REGW_DATA, REGR_TURN or TX_DATA.
- Register write:
  - REGW_DATA: NXT=1; the consumed byte is written to reg[addr].
  - REGW_STP: NXT=0; returns to IDLE regardless of ULPI_STP.
  - Writes to 0x00–0x03 are dropped.
- Register read:
  - REGR_TURN: DIR=1, NXT=0, DATA_OUT=0x00.
  - REGR_DATA: DIR=1, DATA_OUT=reg[addr].
  - Then IDLE with DIR=0.
- Transmit:
  - The PID byte {~PID,PID} is placed in a one-byte hold register.
  - TX_DATA holds NXT=1. Each consumed byte emits the held byte (TX_VALID) and replaces it.
  - ULPI_STP=1 with DATA_IN≠0xFF: emit the held byte with TX_EOP=1, go to IDLE.
  - ULPI_STP=1 with DATA_IN=0xFF: discard the held byte, pulse TX_ABORT, go to IDLE.
  - Nothing is consumed in the STP cycle.
- RX packet:
  - RX_TURN: DIR=1, NXT=0, RX_READY=1.
  - RX_DATA:
    - A byte accepted at the previous edge → DATA_OUT=that byte, NXT=1.
    - Otherwise DATA_OUT={6'b0,LINESTATE} (RX CMD), NXT=0.
    - RX_READY=1 until the RX_LAST byte is accepted.
    - The cycle after the last byte is presented: IDLE, DIR=0.
- Line-state RX CMD:
  - RXCMD_TURN: DIR=1, NXT=0.
  - RXCMD_DATA: DATA_OUT={6'b0,LINESTATE}, NXT=0; latch LINESTATE as the reported value.
  - Then IDLE.
- Register map: 64×8. Addresses 0x04–0x3F reset to 0x00.

## Timing
- Reset: DIR, NXT, RX_READY, TX_VALID, TX_EOP and TX_ABORT = 0; DATA_OUT=0x00; state IDLE; reported linestate = 2'b00; registers 0x04–0x3F = 0x00.
- Reset mid-operation aborts with no TX_EOP or TX_ABORT pulse.
- All outputs are registered from state; there are no combinational paths from input to output.
- Latency:
  - Command seen at edge k → NXT=1 in cycle k+1.
  - Register read data on DATA_OUT 2 cycles after CMD_ACK.
  - RX byte accepted at edge k → on DATA_OUT in cycle k+1.
  - TX_DATA lags consumption by one byte.

## Structure
- Package ulpi_pkg holds:
  - command codes (CMD_IDLE, CMD_TX, CMD_REGW, CMD_REGR);
  - ID register addresses;
  - the abort byte 0xFF;
  - the state encoding (shared with the link block).
- Sub-module ulpi_reg_file: 64×8 storage, synchronous write, combinational read, ID addresses tied to the parameters.

## Test plan
- Register write then read: link writes 0x5A to address 0x16, then reads address 0x16 → NXT pattern 1,1,0; DIR high for 2 cycles; DATA_OUT=0x5A in the second DIR cycle.
- ID read: read address 0x00, then 0x01 → 0x24, then 0x04; a write to 0x02 leaves the readback at 0x09.
- Transmit: TX CMD 0x43, data 0x11 0x22, then STP with 0x00 → TX_DATA sequence 0xC3, 0x11, 0x22; TX_EOP set only on 0x22.
- TX abort: TX CMD 0x41, data 0x33, then STP with 0xFF → 0xE1 emitted; TX_ABORT pulses once; no TX_EOP.
- RX with a gap: bytes 0xA5, (RX_VALID low for 1 cycle), 0x3C with RX_LAST, LINESTATE=2'b01 → DATA_OUT sequence A5/NXT=1, 01/NXT=0, 3C/NXT=1; DIR falls the next cycle.
- Collision and reset: TX CMD 0x8A coincides with RX_VALID → register write completes first, then RX starts. ULPI_RST_N pulled low during RX_DATA → DIR=0 asynchronously.
